// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
//
// Streaming RV32I instruction encoder. Decoded instruction fields plus a
// format type are packed into a 32-bit instruction word, buffered in a
// 2-entry FIFO and handed to the instruction-memory loader together with a
// sequentially assigned, wrapping byte address.
//
// Parameters:
//   BASE_ADDR  byte address of the first word (4-byte aligned)
//   DEPTH      words in the target region; the address wraps after DEPTH words
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   clear                  synchronous flush of buffer, address and count
//   in_valid / in_ready    input handshake
//   in_type                format (TYPE_R/I/S/B/U/J), others encode as NOP
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm
//                          decoded instruction fields
//   out_valid / out_ready  output handshake
//   out_inst, out_addr     encoded word and its byte address
//   inst_count             words delivered since reset/clear (saturating)
//   err                    immediate not representable (INST_ENCODER_CHECK_EN)
//
// Optional feature: define INST_ENCODER_CHECK_EN to add the immediate range
// check and the err port. Without it, out-of-range immediate bits are dropped.
// -----------------------------------------------------------------------------

`ifndef TYPE_R
`define TYPE_R 3'd0
`endif
`ifndef TYPE_I
`define TYPE_I 3'd1
`endif
`ifndef TYPE_S
`define TYPE_S 3'd2
`endif
`ifndef TYPE_B
`define TYPE_B 3'd3
`endif
`ifndef TYPE_U
`define TYPE_U 3'd4
`endif
`ifndef TYPE_J
`define TYPE_J 3'd5
`endif

module inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_type,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
`ifdef INST_ENCODER_CHECK_EN
    output logic        err,
`endif
    output logic [15:0] inst_count
);

    localparam logic [31:0] NOP_INST  = 32'h0000_0013;
    localparam logic [31:0] LAST_ADDR = BASE_ADDR + (32'(DEPTH) - 32'd1) * 32'd4;

    // ------------------------------------------------------------------
    // Field packing
    // ------------------------------------------------------------------
    logic [31:0] enc_inst;

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        enc_inst = NOP_INST;
        case (in_type)
            `TYPE_R: enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            `TYPE_I: enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            `TYPE_S: enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            `TYPE_B: enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                 in_imm[4:1], in_imm[11], in_opcode};
            `TYPE_U: enc_inst = {in_imm[31:12], in_rd, in_opcode};
            `TYPE_J: enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                 in_rd, in_opcode};
            default: enc_inst = NOP_INST;
        endcase
    end

`ifdef INST_ENCODER_CHECK_EN
    // An immediate fits an N-bit signed field when every bit from N-1 upward
    // equals the sign bit, i.e. that upper slice is all ones or all zeros.
    logic i_fits, b_fits, j_fits, enc_err;

    assign i_fits = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign b_fits = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign j_fits = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        enc_err = 1'b0;
        case (in_type)
            `TYPE_I, `TYPE_S: enc_err = ~i_fits;
            `TYPE_B:          enc_err = ~b_fits | in_imm[0];
            `TYPE_J:          enc_err = ~j_fits | in_imm[0];
            `TYPE_U:          enc_err = |in_imm[11:0];
            default:          enc_err = 1'b0;
        endcase
    end
`else
    // Branch/jump offsets are always even, so imm[0] is never packed.
    logic unused_imm0;
    assign unused_imm0 = in_imm[0];
`endif

    // ------------------------------------------------------------------
    // 2-entry FIFO, address counter and delivery count
    // ------------------------------------------------------------------
    logic [31:0] mem_q [0:1];
`ifdef INST_ENCODER_CHECK_EN
    logic        err_mem_q [0:1];
`endif
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] inst_count_q, inst_count_d;
    logic        push, pop;

    // clear blocks both handshakes in its cycle, so nothing moves while flushing.
    assign in_ready  = (cnt_q != 2'd2) && !clear;
    assign out_valid = (cnt_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !clear;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        inst_count_d = inst_count_q;
        if (clear) begin
            wr_ptr_d     = 1'b0;
            rd_ptr_d     = 1'b0;
            cnt_d        = 2'd0;
            addr_d       = BASE_ADDR;
            inst_count_d = 16'd0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
                addr_d   = (addr_q == LAST_ADDR) ? BASE_ADDR : addr_q + 32'd4;
                if (inst_count_q != 16'hFFFF) begin
                    inst_count_d = inst_count_q + 16'd1;
                end
            end
            if (push && !pop) begin
                cnt_d = cnt_q + 2'd1;
            end else if (pop && !push) begin
                cnt_d = cnt_q - 2'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            cnt_q        <= 2'd0;
            addr_q       <= BASE_ADDR;
            inst_count_q <= 16'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            inst_count_q <= inst_count_d;
        end
    end

    // NOTE: the storage is reset because out_inst/err read it directly and must
    // show zero after reset; at two entries this costs almost nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= 32'd0;
`ifdef INST_ENCODER_CHECK_EN
                err_mem_q[i] <= 1'b0;
`endif
            end
        end else if (push) begin
            // With occupancy below two the write slot never aliases the head
            // entry while it is valid, so a stalled output stays stable.
            mem_q[wr_ptr_q] <= enc_inst;
`ifdef INST_ENCODER_CHECK_EN
            err_mem_q[wr_ptr_q] <= enc_err;
`endif
        end
    end

    assign out_inst   = mem_q[rd_ptr_q];
    assign out_addr   = addr_q;
    assign inst_count = inst_count_q;
`ifdef INST_ENCODER_CHECK_EN
    assign err        = err_mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_inst_encoder
//
// Scoreboard bench for inst_encoder. The stimulus side records each accepted
// input's hand-computed word and its model address in a queue; an independent
// monitor pops and compares on every delivered word. A second instance with
// BASE_ADDR=0x100, DEPTH=4 runs in lockstep to exercise address wrap.
// -----------------------------------------------------------------------------

`timescale 1ns/1ps

`ifndef TYPE_R
`define TYPE_R 3'd0
`endif
`ifndef TYPE_I
`define TYPE_I 3'd1
`endif
`ifndef TYPE_S
`define TYPE_S 3'd2
`endif
`ifndef TYPE_B
`define TYPE_B 3'd3
`endif
`ifndef TYPE_U
`define TYPE_U 3'd4
`endif
`ifndef TYPE_J
`define TYPE_J 3'd5
`endif

module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  in_type = 3'd0;
    logic [6:0]  in_opcode = 7'd0;
    logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [6:0]  in_funct7 = 7'd0;
    logic [31:0] in_imm = 32'd0;

    logic        in_ready, out_valid;
    logic [31:0] out_inst, out_addr;
    logic [15:0] inst_count;
    logic        w_in_ready, w_out_valid;
    logic [31:0] w_out_inst, w_out_addr;
    logic [15:0] w_inst_count;
`ifdef INST_ENCODER_CHECK_EN
    logic        err, w_err;
`endif

    always #5 clk = ~clk;

    inst_encoder u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr),
`ifdef INST_ENCODER_CHECK_EN
        .err(err),
`endif
        .inst_count(inst_count)
    );

    inst_encoder #(.BASE_ADDR(32'h0000_0100), .DEPTH(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(w_in_ready),
        .in_type(in_type), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_inst(w_out_inst), .out_addr(w_out_addr),
`ifdef INST_ENCODER_CHECK_EN
        .err(w_err),
`endif
        .inst_count(w_inst_count)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] exp_inst = 32'd0;
    logic        exp_err = 1'b0;
    int          push_idx = 0;
    int          wrap_idx = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard push: an input accepted at the coming edge gets the k-th
    // address since reset/clear, because delivery is strict FIFO.
    always @(negedge clk) begin
        if (!rst_n || clear) begin
            sb_q.delete();
            push_idx = 0;
        end else if (in_valid && in_ready) begin
            exp_t e;
            e.inst = exp_inst;
            e.addr = 32'(push_idx % 1024) * 32'd4;
            e.err  = exp_err;
            sb_q.push_back(e);
            push_idx++;
        end
    end

    // Monitor: compares each word delivered at the coming edge.
    always @(negedge clk) begin
        if (rst_n && !clear && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_word: got %h, expected no word", out_inst);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_inst", out_inst, e.inst);
                check("out_addr", out_addr, e.addr);
`ifdef INST_ENCODER_CHECK_EN
                check("err", 32'(err), 32'(e.err));
`endif
            end
        end
    end

    // Wrap instance monitor: address model 0x100 + 4*(k mod 4).
    always @(negedge clk) begin
        if (!rst_n || clear) begin
            wrap_idx = 0;
        end else if (w_out_valid && out_ready) begin
            check("wrap_addr", w_out_addr, 32'h100 + 32'(wrap_idx % 4) * 32'd4);
            wrap_idx++;
        end
    end

    // Drive one input and hold it until accepted (bounded); returns 1ns after
    // the accepting edge with in_valid dropped.
    task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] ei, input logic ee);
        bit accepted;
        accepted  = 1'b0;
        in_type   = t;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        exp_inst  = ei;
        exp_err   = ee;
        in_valid  = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (accepted) begin
            @(posedge clk);
            #1;
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0, expected acceptance");
        end
        in_valid = 1'b0;
    endtask

    // Send with out_ready high and confirm the word is visible one cycle later.
    task automatic send_lat(input string name, input logic [2:0] t, input logic [6:0] op,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                            input logic [31:0] ei, input logic ee);
        send(t, op, rd, rs1, rs2, f3, f7, imm, ei, ee);
        check({"latency_", name}, 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_addr", out_addr, 32'd0);
        check("rst_inst_count", 32'(inst_count), 32'd0);
        check("rst_wrap_addr", w_out_addr, 32'h100);
`ifdef INST_ENCODER_CHECK_EN
        check("rst_err", 32'(err), 32'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Encoding: one input per format plus a NOP and range-check cases.
        out_ready = 1'b1;
        send_lat("add",  `TYPE_R, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,        32'h002081B3, 1'b0);
        send_lat("addi", `TYPE_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
        send_lat("sw",   `TYPE_S, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4,        32'h0020A223, 1'b0);
        send_lat("beq",  `TYPE_B, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,        32'h00208463, 1'b0);
        send_lat("lui",  `TYPE_U, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
        send_lat("jal",  `TYPE_J, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFFDFF0EF, 1'b0);
        send_lat("nop",  3'd7,    7'b0110011, 5'd7, 5'd7, 5'd7, 3'd7, 7'd5, 32'h1234,     32'h00000013, 1'b0);
        send_lat("i2048", `TYPE_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,    32'h80000093, 1'b1);
        send_lat("im2048", `TYPE_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h80000093, 1'b0);
        send_lat("b7",   `TYPE_B, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7,        32'h00208363, 1'b1);
        check("enc_count", 32'(inst_count), 32'd10);

        // Backpressure: two accepted, third held until the output drains.
        pulse_clear();
        check("clr_addr", out_addr, 32'd0);
        check("clr_count", 32'(inst_count), 32'd0);
        out_ready = 1'b0;
        send(`TYPE_R, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1'b0);
        send(`TYPE_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
        fork
            send(`TYPE_S, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4, 32'h0020A223, 1'b0);
            begin
                repeat (3) @(negedge clk);
                check("bp_in_ready", 32'(in_ready), 32'd0);
                check("bp_out_inst_hold", out_inst, 32'h002081B3);
                check("bp_count", 32'(inst_count), 32'd0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_final_count", 32'(inst_count), 32'd3);

        // Wrap: five deliveries on the DEPTH=4 instance.
        pulse_clear();
        for (int i = 0; i < 5; i++) begin
            send_lat("wrap", `TYPE_U, 7'b0110111, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0,
                     32'h12345000, {20'h12345, 5'(i), 7'b0110111}, 1'b0);
        end
        check("wrap_count", 32'(w_inst_count), 32'd5);
        check("main_count", 32'(inst_count), 32'd5);
        check("wrap_addr_after", w_out_addr, 32'h104);

        // Clear with two words buffered and a simultaneous push.
        out_ready = 1'b0;
        send(`TYPE_R, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1'b0);
        send(`TYPE_R, 7'b0110011, 5'd4, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h00208233, 1'b0);
        in_valid = 1'b1;
        clear    = 1'b1;
        @(negedge clk);
        check("clr_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_out_valid", 32'(out_valid), 32'd0);
        check("clr_inst_count", 32'(inst_count), 32'd0);
        check("clr_out_addr", out_addr, 32'd0);
        check("clr_wrap_valid", 32'(w_out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("clr_no_accept", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stream.
        out_ready = 1'b1;
        send(`TYPE_R, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1'b0);
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(`TYPE_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
        send(`TYPE_S, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4, 32'h0020A223, 1'b0);
        check("pre_rst_addr", out_addr, 32'd4);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_inst", out_inst, 32'd0);
        check("arst_out_addr", out_addr, 32'd0);
        check("arst_inst_count", 32'(inst_count), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
`ifdef INST_ENCODER_CHECK_EN
        check("arst_err", 32'(err), 32'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
